// File: rtl/shift_sequencer.sv
// Purpose     : multi-cycle shift/rotate stage that feeds an 8-bit circular shifter
//               (at most MAX_STEP positions per RUN cycle) and registers Result/CarryOut/Zero.
// Latency     : Done 1 cycle after accept for a zero count, 2 for counts 1..7, 3 for 8..9
//               (RCL/RCR: 1 + count).
// Backpressure: ReqReady is low only in RUN. Requests offered during RUN are dropped, not queued.
//
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   ReqValid / ReqReady  request handshake; the request is taken when both are high at a CLK edge
//   A, Amt, Op, CarryIn  operand, unsigned shift count, operation, incoming carry flag
//   Result, CarryOut     registered result and last bit shifted out; held between updates
//   Zero                 registered (Result == 0)
//   Done                 one-cycle pulse in the cycle the registered outputs take new values
//   Busy                 high while the operation is iterating (RUN)
//
// Optional feature: define SHIFT_SEQ_RCX_EN to add RCL (Op 101) and RCR (Op 110). These are
// 9-bit rotates through carry that advance one bit per cycle. Without the macro, Op 101 and
// Op 110 behave as no-ops, like Op 111.

module shift_sequencer #(
  parameter int WIDTH    = 8,  // only 8 is supported; the rotate/mask logic assumes it
  parameter int MAX_STEP = 7   // largest amount handed to the rotator in one RUN cycle
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [WIDTH-1:0] A,
  input  logic [7:0]       Amt,
  input  logic [2:0]       Op,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Done,
  output logic             Busy
);

  // --------------------------------------------------------------------------
  // Operation encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
`ifdef SHIFT_SEQ_RCX_EN
  localparam logic [2:0] OP_RCL = 3'b101;
  localparam logic [2:0] OP_RCR = 3'b110;
`endif
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Working copy of the operation; it is only meaningful between accept and DONE.
  logic [WIDTH-1:0] work_q, work_d;
  logic [2:0]       op_q;
  logic             carry_q, carry_d;
  logic [3:0]       remain_q, remain_d;  // positions still to apply (0..9)

  logic             accept;
  logic [3:0]       load_remain;
  logic [2:0]       step;
  logic             last_step;
  logic [2:0]       idx_l, idx_r;
  logic [WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0] vac_l, vac_r;

  // Result register write port, driven by the FSM process.
  logic             res_we;
  logic [WIDTH-1:0] res_d;
  logic             res_cy_d;

  // --------------------------------------------------------------------------
  // Count decode at accept time.
  // A rotate by 8 is the identity, so only Amt[2:0] matters. Shifts saturate
  // at 9: by then every original bit, and the last carry candidate, has gone.
  // --------------------------------------------------------------------------
  always_comb begin
    load_remain = 4'd0;
    case (Op)
      OP_ROL, OP_ROR:         load_remain = {1'b0, Amt[2:0]};
      OP_SHL, OP_SHR, OP_ASR: load_remain = (Amt > 8'd9) ? 4'd9 : Amt[3:0];
`ifdef SHIFT_SEQ_RCX_EN
      OP_RCL, OP_RCR:         load_remain = 4'(Amt % 8'd9);
`endif
      default:                load_remain = 4'd0;  // no-op encodings
    endcase
  end

  // --------------------------------------------------------------------------
  // One RUN iteration: rotate the work value, then overwrite the vacated bits.
  // --------------------------------------------------------------------------
  always_comb begin
    step = (remain_q > 4'(MAX_STEP)) ? 3'(MAX_STEP) : remain_q[2:0];
`ifdef SHIFT_SEQ_RCX_EN
    // Rotate-through-carry is a 9-bit rotate and cannot use the 8-bit rotator.
    // It is done one bit at a time instead.
    if (op_q == OP_RCL || op_q == OP_RCR) begin
      step = 3'd1;
    end
`endif

    // Position of the last bit that leaves the word. 3'd0 - step equals 8 - step
    // for steps 1..7, so the index wraps correctly in 3 bits.
    idx_l = 3'd0 - step;
    idx_r = step - 3'd1;

    rot_l = (work_q << step) | (work_q >> (4'd8 - {1'b0, step}));
    rot_r = (work_q >> step) | (work_q << (4'd8 - {1'b0, step}));

    // Masks that select the bit positions vacated by a shift of 'step'.
    vac_l = ~({WIDTH{1'b1}} << step);
    vac_r = ~({WIDTH{1'b1}} >> step);

    work_d  = work_q;
    carry_d = carry_q;
    case (op_q)
      OP_ROL: begin
        work_d  = rot_l;
        carry_d = work_q[idx_l];
      end
      OP_SHL: begin
        work_d  = rot_l & ~vac_l;
        carry_d = work_q[idx_l];
      end
      OP_ROR: begin
        work_d  = rot_r;
        carry_d = work_q[idx_r];
      end
      OP_SHR: begin
        work_d  = rot_r & ~vac_r;
        carry_d = work_q[idx_r];
      end
      OP_ASR: begin
        // The sign bit stays in place across steps, so work_q[7] is the original sign.
        work_d  = work_q[WIDTH-1] ? (rot_r | vac_r) : (rot_r & ~vac_r);
        carry_d = work_q[idx_r];
      end
`ifdef SHIFT_SEQ_RCX_EN
      OP_RCL: begin
        work_d  = {work_q[WIDTH-2:0], carry_q};
        carry_d = work_q[WIDTH-1];
      end
      OP_RCR: begin
        work_d  = {carry_q, work_q[WIDTH-1:1]};
        carry_d = work_q[0];
      end
`endif
      default: begin
        work_d  = work_q;
        carry_d = carry_q;
      end
    endcase

    remain_d  = remain_q - {1'b0, step};
    last_step = (remain_q == {1'b0, step});
  end

  // --------------------------------------------------------------------------
  // FSM: next state, handshake/status outputs, result write enable.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ReqReady = (state_q != S_RUN);
    Busy     = (state_q == S_RUN);
    Done     = (state_q == S_DONE);
    accept   = ReqValid && (state_q != S_RUN);
    res_we   = 1'b0;
    res_d    = Result;
    res_cy_d = CarryOut;

    case (state_q)
      // DONE accepts exactly like IDLE, so a held request is taken back to back.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (load_remain == 4'd0) begin
            // Nothing to shift: the operand and carry pass straight through.
            state_d  = S_DONE;
            res_we   = 1'b1;
            res_d    = A;
            res_cy_d = CarryIn;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_d  = S_DONE;
          res_we   = 1'b1;
          res_d    = work_d;
          res_cy_d = carry_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Work registers and the architecturally visible result/flags.
  // The result registers change only on the edge that enters DONE, so they
  // never take intermediate values while in RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work_q   <= '0;
      op_q     <= OP_NOP;
      carry_q  <= 1'b0;
      remain_q <= 4'd0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
    end else begin
      if (accept) begin
        work_q   <= A;
        op_q     <= Op;
        carry_q  <= CarryIn;
        remain_q <= load_remain;
      end else if (state_q == S_RUN) begin
        work_q   <= work_d;
        carry_q  <= carry_d;
        remain_q <= remain_d;
      end
      if (res_we) begin
        Result   <= res_d;
        CarryOut <= res_cy_d;
        Zero     <= (res_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases, back-to-back, dropped requests,
// reset mid-operation, then randomized operations against an arithmetic model.

module tb_shift_sequencer;

  logic       CLK      = 1'b0;
  logic       RST_N    = 1'b0;
  logic       ReqValid = 1'b0;
  logic [7:0] A        = 8'h00;
  logic [7:0] Amt      = 8'h00;
  logic [2:0] Op       = 3'b000;
  logic       CarryIn  = 1'b0;
  logic       ReqReady;
  logic [7:0] Result;
  logic       CarryOut;
  logic       Zero;
  logic       Done;
  logic       Busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  shift_sequencer dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .A        (A),
    .Amt      (Amt),
    .Op       (Op),
    .CarryIn  (CarryIn),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Zero     (Zero),
    .Done     (Done),
    .Busy     (Busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the result is computed directly from the operation
  // definitions with integer arithmetic, as a single shift of the full count.
  function automatic void model(input int a, input int amt, input int op, input int cin,
                                output int r, output int c, output int lat);
    int n;
    int v;
    int sa;
    r  = a;
    c  = cin;
    lat = 1;
    sa = (a >= 128) ? a - 256 : a;
    case (op)
      0, 1:    n = amt % 8;
      2, 3, 4: n = (amt > 9) ? 9 : amt;
`ifdef SHIFT_SEQ_RCX_EN
      5, 6:    n = amt % 9;
`endif
      default: n = 0;
    endcase
    if (n != 0) begin
      lat = (n > 7) ? 3 : 2;
      case (op)
        0: begin r = ((a << n) | (a >> (8 - n))) & 255; c = r & 1; end
        1: begin r = ((a >> n) | (a << (8 - n))) & 255; c = (r >> 7) & 1; end
        2: begin v = a << n; r = v & 255; c = (v >> 8) & 1; end
        3: begin r = a >> n; c = (a >> (n - 1)) & 1; end
        4: begin r = (sa >>> n) & 255; c = (sa >>> (n - 1)) & 1; end
`ifdef SHIFT_SEQ_RCX_EN
        5: begin
          v = (cin << 8) | a;
          v = ((v << n) | (v >> (9 - n))) & 511;
          r = v & 255; c = (v >> 8) & 1; lat = 1 + n;
        end
        6: begin
          v = (cin << 8) | a;
          v = ((v >> n) | (v << (9 - n))) & 511;
          r = v & 255; c = (v >> 8) & 1; lat = 1 + n;
        end
`endif
        default: ;
      endcase
    end
  endfunction

  // Called just after the accepting edge. Counts edges until Done is seen
  // (bounded), checking in the meantime that the DUT stays busy and holds its
  // result. Returns at the falling edge of the Done cycle.
  task automatic wait_done(input string tag, input int er, input int ec, input int el,
                           input logic [7:0] held);
    int lat;
    bit seen;
    bit run_ok;
    lat    = 0;
    seen   = 1'b0;
    run_ok = 1'b1;
    while (!seen && lat < 16) begin
      @(negedge CLK);
      lat++;
      if (Done) seen = 1'b1;
      else if (!Busy || ReqReady || Result !== held) run_ok = 1'b0;
    end
    check({tag, "_lat"}, lat, el);
    check({tag, "_res"}, Result, er);
    check({tag, "_cy"}, CarryOut, ec);
    check({tag, "_z"}, Zero, (er == 0));
    check({tag, "_run"}, run_ok, 1);
    check({tag, "_dflags"}, {Busy, ReqReady}, 2'b01);
  endtask

  // Starts at posedge+1 with the DUT idle. Ends at posedge+1 after the Done cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] amt,
                        input logic [2:0] op, input logic cin);
    int er;
    int ec;
    int el;
    logic [7:0] held;
    model(a, amt, op, cin, er, ec, el);
    ReqValid = 1'b1; A = a; Amt = amt; Op = op; CarryIn = cin;
    @(negedge CLK);
    check({tag, "_idle"}, {Done, Busy, ReqReady}, 3'b001);
    held = Result;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    A = 8'($urandom); Amt = 8'($urandom); Op = 3'($urandom); CarryIn = 1'($urandom);
    wait_done(tag, er, ec, el, held);
    @(posedge CLK); #1;
  endtask

  logic [7:0] d_a   [0:11] = '{8'h81, 8'h96, 8'h55, 8'h01, 8'h80, 8'h80,
                               8'hC3, 8'h80, 8'h7F, 8'hF0, 8'h3C, 8'h01};
  logic [7:0] d_amt [0:11] = '{8'd1, 8'd12, 8'd0, 8'd8, 8'd200, 8'd1,
                               8'd16, 8'd8, 8'd8, 8'd9, 8'd5, 8'd4};
  logic [2:0] d_op  [0:11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5,
                               3'd0, 3'd3, 3'd4, 3'd2, 3'd7, 3'd6};
  logic       d_cin [0:11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int er1, ec1, el1, er2, ec2, el2;
    logic [7:0] held;

    // Reset state (reset asserted from time 0, first rising edge already seen).
    @(negedge CLK);
    check("rst_result", Result, 8'h00);
    check("rst_flags", {CarryOut, Zero, Done, Busy, ReqReady}, 5'b01001);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Directed cases, including the count boundaries.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("dir%0d", i), d_a[i], d_amt[i], d_op[i], d_cin[i]);
    end

    // Back-to-back: the second request is held through RUN and taken in DONE.
    model(8'h01, 8, 2, 0, er1, ec1, el1);
    model(8'h0F, 3, 1, 1, er2, ec2, el2);
    held = Result;
    ReqValid = 1'b1; A = 8'h01; Amt = 8'd8; Op = 3'd2; CarryIn = 1'b0;
    @(posedge CLK); #1;
    A = 8'h0F; Amt = 8'd3; Op = 3'd1; CarryIn = 1'b1;
    wait_done("b2b1", er1, ec1, el1, held);
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    wait_done("b2b2", er2, ec2, el2, 8'(er1));
    @(posedge CLK); #1;

    // A request pulse during RUN is dropped.
    model(8'hAB, 9, 2, 1, er1, ec1, el1);
    ReqValid = 1'b1; A = 8'hAB; Amt = 8'd9; Op = 3'd2; CarryIn = 1'b1;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    @(posedge CLK); #1;
    ReqValid = 1'b1; A = 8'h55; Amt = 8'd1; Op = 3'd0; CarryIn = 1'b0;
    @(negedge CLK);
    check("drop_rdy", {Busy, ReqReady}, 2'b10);
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    @(negedge CLK);
    check("drop_done", Done, 1);
    check("drop_res", Result, er1);
    check("drop_cy", CarryOut, ec1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("drop_quiet", {Done, Busy}, 2'b00);
    end
    check("drop_hold", Result, er1);
    @(posedge CLK); #1;

    // Reset in the first RUN cycle discards the operation.
    run_op("pre_rst", 8'h81, 8'd1, 3'd0, 1'b0);
    ReqValid = 1'b1; A = 8'hFF; Amt = 8'd9; Op = 3'd2; CarryIn = 1'b1;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    check("rst_pre_busy", Busy, 1);
    #2; RST_N = 1'b0; #1;
    check("rst_mid_res", Result, 8'h00);
    check("rst_mid_flags", {CarryOut, Zero, Done, Busy, ReqReady}, 5'b01001);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("rst_mid_nodone", {Done, Busy}, 2'b00);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    run_op("post_rst", 8'h01, 8'd3, 3'd0, 1'b0);
    check("post_rst_lit", Result, 8'h08);

    // Randomized operations.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [7:0] ramt;
      ra   = 8'($urandom);
      ramt = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 18)) : 8'($urandom);
      run_op($sformatf("rnd%0d", i), ra, ramt, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
